// File: rtl/issue_unit.sv
// Issue stage: grants one ready queue per cycle, runs the op on the int ALU, multiplier or divider,
// and books every result onto the single CDB slot so no two results ever collide.
module issue_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic [31:0] rsdata,
  input  logic [31:0] rtdata,
  input  logic [5:0]  rdtag,
  input  logic        ready_int,
  input  logic        ready_mult,
  input  logic        ready_div,
  input  logic        ready_ld_buf,
  output logic        issue_int,
  output logic        issue_mult,
  output logic        issue_div,
  output logic        issue_ld_buf,
  output logic        issue_carryout,
  output logic        issue_overflow,
  output logic        issue_div_done,
  output logic [31:0] cdb_out,
  output logic [5:0]  cdb_tagout,
  output logic        cdb_valid,
  output logic        cdb_branch,
  output logic        cdb_branch_taken
);

  // resv_q[k]: CDB already owned k cycles from now
  logic [33:1] resv_q, resv_d;

  logic        div_run_q, div_done_q, div_busy, div_last, div_ge;
  logic [4:0]  div_cnt_q;
  logic [31:0] div_rem_q, div_quo_q, div_den_q, div_rem_n, div_quo_n, div_trial;
  logic [32:0] div_shift;
  logic [5:0]  div_tag_q;

  logic [2:0]  mul_vld_q;
  logic [31:0] mul_a_q, mul_b_q, mul_p2_q, mul_p3_q, mul_lo;
  logic [5:0]  mul_tag1_q, mul_tag2_q, mul_tag3_q;

  logic [32:0] add_sum, sub_diff;
  logic [31:0] alu_res;
  logic        alu_cy, alu_ov, alu_br, alu_tk;

  logic [31:0] cdb_out_d;
  logic [5:0]  cdb_tag_d;
  logic        cdb_valid_d, cdb_br_d, cdb_tk_d, cdb_cy_d, cdb_ov_d;

  assign div_busy = div_run_q | div_done_q;

  always_comb begin
    issue_div    = 1'b0;
    issue_mult   = 1'b0;
    issue_int    = 1'b0;
    issue_ld_buf = 1'b0;
    if (reset) begin
      if (ready_div && !div_busy && !resv_q[33]) issue_div = 1'b1;
      else if (ready_mult && !resv_q[4])         issue_mult = 1'b1;
      else if (ready_int && !resv_q[1])          issue_int = 1'b1;
      else if (ready_ld_buf && !resv_q[1])       issue_ld_buf = 1'b1;
    end
  end

  // Bits are booked post-shift, so a latency-L grant lands at index L-1.
  always_comb begin
    resv_d = {1'b0, resv_q[33:2]};
    if (issue_div)  resv_d[32] = 1'b1;
    if (issue_mult) resv_d[3]  = 1'b1;
  end

  assign add_sum  = {1'b0, rsdata} + {1'b0, rtdata};
  assign sub_diff = {1'b0, rsdata} + {1'b0, ~rtdata} + 33'd1;

  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    alu_ov  = 1'b0;
    alu_br  = 1'b0;
    alu_tk  = 1'b0;
    case (opcode)
      4'h0: begin
        alu_res = add_sum[31:0];
        alu_cy  = add_sum[32];
        alu_ov  = (rsdata[31] == rtdata[31]) && (add_sum[31] != rsdata[31]);
      end
      4'h1: begin
        alu_res = add_sum[31:0];
        alu_cy  = add_sum[32];
      end
      4'h2: begin
        alu_res = sub_diff[31:0];
        alu_cy  = sub_diff[32];
        alu_ov  = (rsdata[31] != rtdata[31]) && (sub_diff[31] != rsdata[31]);
      end
      4'h3: begin
        alu_res = sub_diff[31:0];
        alu_cy  = sub_diff[32];
      end
      4'h4: alu_res = rsdata & rtdata;
      4'h5: alu_res = rsdata | rtdata;
      4'h6: alu_res = ~(rsdata | rtdata);
      4'h7: alu_res = {31'b0, $signed(rsdata) < $signed(rtdata)};
      4'h8: alu_res = {31'b0, rsdata < rtdata};
      4'h9: begin
        alu_br = 1'b1;
        alu_tk = (rsdata == rtdata);
      end
      4'hA: begin
        alu_br = 1'b1;
        alu_tk = (rsdata != rtdata);
      end
      default: alu_res = '0;
    endcase
  end

  assign mul_lo = mul_a_q * mul_b_q;

  // Restoring step; a zero divisor always "fits", yielding an all-ones quotient.
  assign div_shift = {div_rem_q, div_quo_q[31]};
  assign div_ge    = (div_shift >= {1'b0, div_den_q});
  assign div_trial = div_shift[31:0] - div_den_q;
  assign div_rem_n = div_ge ? div_trial : div_shift[31:0];
  assign div_quo_n = {div_quo_q[30:0], div_ge};
  assign div_last  = div_run_q && (div_cnt_q == 5'd31);

  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_out_d   = '0;
    cdb_tag_d   = '0;
    cdb_br_d    = 1'b0;
    cdb_tk_d    = 1'b0;
    cdb_cy_d    = 1'b0;
    cdb_ov_d    = 1'b0;
    if (issue_int) begin
      cdb_valid_d = 1'b1;
      cdb_out_d   = alu_res;
      cdb_tag_d   = rdtag;
      cdb_br_d    = alu_br;
      cdb_tk_d    = alu_tk;
      cdb_cy_d    = alu_cy;
      cdb_ov_d    = alu_ov;
    end else if (issue_ld_buf) begin
      cdb_valid_d = 1'b1;
      cdb_out_d   = rsdata;
      cdb_tag_d   = rdtag;
    end else if (mul_vld_q[2]) begin
      cdb_valid_d = 1'b1;
      cdb_out_d   = mul_p3_q;
      cdb_tag_d   = mul_tag3_q;
    end else if (div_last) begin
      cdb_valid_d = 1'b1;
      cdb_out_d   = div_quo_n;
      cdb_tag_d   = div_tag_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resv_q           <= '0;
      mul_vld_q        <= '0;
      mul_a_q          <= '0;
      mul_b_q          <= '0;
      mul_p2_q         <= '0;
      mul_p3_q         <= '0;
      mul_tag1_q       <= '0;
      mul_tag2_q       <= '0;
      mul_tag3_q       <= '0;
      div_run_q        <= 1'b0;
      div_done_q       <= 1'b0;
      div_cnt_q        <= '0;
      div_rem_q        <= '0;
      div_quo_q        <= '0;
      div_den_q        <= '0;
      div_tag_q        <= '0;
      cdb_valid        <= 1'b0;
      cdb_out          <= '0;
      cdb_tagout       <= '0;
      cdb_branch       <= 1'b0;
      cdb_branch_taken <= 1'b0;
      issue_carryout   <= 1'b0;
      issue_overflow   <= 1'b0;
    end else begin
      resv_q     <= resv_d;
      mul_vld_q  <= {mul_vld_q[1:0], issue_mult};
      mul_a_q    <= rsdata;
      mul_b_q    <= rtdata;
      mul_tag1_q <= rdtag;
      mul_p2_q   <= mul_lo;
      mul_tag2_q <= mul_tag1_q;
      mul_p3_q   <= mul_p2_q;
      mul_tag3_q <= mul_tag2_q;
      div_done_q <= div_last;
      if (issue_div) begin
        div_run_q <= 1'b1;
        div_cnt_q <= '0;
        div_rem_q <= '0;
        div_quo_q <= rsdata;
        div_den_q <= rtdata;
        div_tag_q <= rdtag;
      end else if (div_run_q) begin
        div_rem_q <= div_rem_n;
        div_quo_q <= div_quo_n;
        div_cnt_q <= div_cnt_q + 5'd1;
        if (div_last) div_run_q <= 1'b0;
      end
      cdb_valid        <= cdb_valid_d;
      cdb_out          <= cdb_out_d;
      cdb_tagout       <= cdb_tag_d;
      cdb_branch       <= cdb_br_d;
      cdb_branch_taken <= cdb_tk_d;
      issue_carryout   <= cdb_cy_d;
      issue_overflow   <= cdb_ov_d;
    end
  end

  assign issue_div_done = div_done_q;

endmodule

// File: tb/tb_issue_unit.sv
// Bench for issue_unit: directed cases plus random traffic against a cycle-indexed CDB scoreboard.
module tb_issue_unit;

  localparam int Span = 4096;
  localparam longint MaxS = 64'sh7FFF_FFFF;
  localparam longint MinS = -64'sh8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic [31:0] rsdata, rtdata;
  logic [5:0]  rdtag;
  logic        ready_int, ready_mult, ready_div, ready_ld_buf;
  logic        issue_int, issue_mult, issue_div, issue_ld_buf;
  logic        issue_carryout, issue_overflow, issue_div_done;
  logic [31:0] cdb_out;
  logic [5:0]  cdb_tagout;
  logic        cdb_valid, cdb_branch, cdb_branch_taken;

  issue_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rsdata(rsdata), .rtdata(rtdata), .rdtag(rdtag),
    .ready_int(ready_int), .ready_mult(ready_mult), .ready_div(ready_div),
    .ready_ld_buf(ready_ld_buf), .issue_int(issue_int), .issue_mult(issue_mult),
    .issue_div(issue_div), .issue_ld_buf(issue_ld_buf), .issue_carryout(issue_carryout),
    .issue_overflow(issue_overflow), .issue_div_done(issue_div_done), .cdb_out(cdb_out),
    .cdb_tagout(cdb_tagout), .cdb_valid(cdb_valid), .cdb_branch(cdb_branch),
    .cdb_branch_taken(cdb_branch_taken)
  );

  always #5 clk = ~clk;

  // Expected CDB contents per absolute cycle; a set e_vld also means the slot is booked.
  bit        e_vld [Span];
  bit [31:0] e_data[Span];
  bit [5:0]  e_tag [Span];
  bit        e_br[Span], e_tk[Span], e_cy[Span], e_ov[Span], e_dd[Span];
  int        cyc, div_free_at, n0;
  int        checks = 0, failures = 0;

  logic [47:0] all_outs;
  logic [43:0] cdb_obs;
  assign all_outs = {issue_int, issue_mult, issue_div, issue_ld_buf, issue_carryout,
                     issue_overflow, issue_div_done, cdb_out, cdb_tagout, cdb_valid, cdb_branch,
                     cdb_branch_taken};
  assign cdb_obs = {cdb_valid, cdb_out, cdb_tagout, cdb_branch, cdb_branch_taken, issue_carryout,
                    issue_overflow, issue_div_done};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [43:0] exp_at(int c);
    return {e_vld[c], e_data[c], e_tag[c], e_br[c], e_tk[c], e_cy[c], e_ov[c], e_dd[c]};
  endfunction

  task automatic put(input int c, input bit [31:0] d, input bit [5:0] t, input bit br,
                     input bit tk, input bit cy, input bit ov, input bit dd);
    e_vld[c] = 1'b1; e_data[c] = d; e_tag[c] = t;
    e_br[c] = br; e_tk[c] = tk; e_cy[c] = cy; e_ov[c] = ov; e_dd[c] = dd;
  endtask

  task automatic clear_model();
    for (int i = 0; i < Span; i++) begin
      e_vld[i] = 0; e_data[i] = 0; e_tag[i] = 0;
      e_br[i] = 0; e_tk[i] = 0; e_cy[i] = 0; e_ov[i] = 0; e_dd[i] = 0;
    end
    div_free_at = 0;
  endtask

  task automatic alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] r, output logic br, output logic tk,
                           output logic cy, output logic ov);
    longint sa, sb, s;
    longint unsigned ua, ub;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = 64'(a); ub = 64'(b);
    r = 0; br = 0; tk = 0; cy = 0; ov = 0;
    case (op)
      4'h0: begin r = a + b; cy = (ua + ub) > 64'hFFFF_FFFF; s = sa + sb; ov = s > MaxS || s < MinS; end
      4'h1: begin r = a + b; cy = (ua + ub) > 64'hFFFF_FFFF; end
      4'h2: begin r = a - b; cy = (a >= b); s = sa - sb; ov = s > MaxS || s < MinS; end
      4'h3: begin r = a - b; cy = (a >= b); end
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = ~(a | b);
      4'h7: r = (sa < sb) ? 32'd1 : 32'd0;
      4'h8: r = (a < b) ? 32'd1 : 32'd0;
      4'h9: begin br = 1; tk = (a == b); end
      4'hA: begin br = 1; tk = (a != b); end
      default: r = 0;
    endcase
  endtask

  // Checks grant and CDB for the current cycle, books the granted result, advances one cycle.
  task automatic cycle();
    logic [3:0]  g;
    logic [31:0] r, p;
    logic        br, tk, cy, ov;
    @(negedge clk);
    g = 4'b0000;
    if (ready_div && cyc >= div_free_at && !e_vld[cyc+33]) g = 4'b1000;
    else if (ready_mult && !e_vld[cyc+4])                   g = 4'b0100;
    else if (ready_int && !e_vld[cyc+1])                    g = 4'b0010;
    else if (ready_ld_buf && !e_vld[cyc+1])                 g = 4'b0001;
    chk("grant", {issue_div, issue_mult, issue_int, issue_ld_buf}, g);
    chk("cdb", cdb_obs, exp_at(cyc));
    case (g)
      4'b1000: begin
        put(cyc + 33, (rtdata == 0) ? 32'hFFFF_FFFF : rsdata / rtdata, rdtag, 0, 0, 0, 0, 1);
        div_free_at = cyc + 34;
      end
      4'b0100: begin p = rsdata * rtdata; put(cyc + 4, p, rdtag, 0, 0, 0, 0, 0); end
      4'b0010: begin
        alu_model(opcode, rsdata, rtdata, r, br, tk, cy, ov);
        put(cyc + 1, r, rdtag, br, tk, cy, ov, 0);
      end
      4'b0001: put(cyc + 1, rsdata, rdtag, 0, 0, 0, 0, 0);
      default: ;
    endcase
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input bit ri, input bit rm, input bit rd, input bit rl,
                         input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] t);
    ready_int = ri; ready_mult = rm; ready_div = rd; ready_ld_buf = rl;
    opcode = op; rsdata = a; rtdata = b; rdtag = t;
  endtask

  task automatic idle();
    ready_int = 0; ready_mult = 0; ready_div = 0; ready_ld_buf = 0;
  endtask

  task automatic run_int(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] t);
    set_req(1, 0, 0, 0, op, a, b, t);
    cycle();
    idle();
  endtask

  task automatic hit_reset();
    #2 reset = 1'b0;
    #1 chk("reset_async_outs", all_outs, 48'h0);
    idle();
    @(posedge clk); #1;
    chk("reset_hold_outs", all_outs, 48'h0);
    @(posedge clk); #2;
    reset = 1'b1;
    clear_model();
    @(posedge clk); #1;
    cyc += 3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear_model();
    cyc = 0;
    reset = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("reset_outs", all_outs, 48'h0);
    ready_int = 1; ready_mult = 1; ready_div = 1; ready_ld_buf = 1;
    #1 chk("reset_grants", all_outs, 48'h0);
    idle();
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #1;

    set_req(1, 0, 0, 0, 4'h0, 32'hA, 32'h5, 6'h0E);
    #1 chk("add_grant", issue_int, 1);
    cycle();
    idle();
    chk("add_out", {cdb_valid, cdb_out, cdb_tagout}, {1'b1, 32'hF, 6'h0E});
    chk("add_flags", {issue_carryout, issue_overflow}, 2'b00);

    run_int(4'h0, 32'h7FFF_FFFF, 32'h1, 6'h01);
    chk("add_ovf", {cdb_out, issue_carryout, issue_overflow}, {32'h8000_0000, 2'b01});
    run_int(4'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'h02);
    chk("add_carry", {cdb_out, issue_carryout, issue_overflow}, {32'hFFFF_FFFE, 2'b10});
    run_int(4'h7, 32'd5, 32'd6, 6'h03);
    chk("slt_true", cdb_out, 32'd1);
    run_int(4'h7, 32'd6, 32'd5, 6'h04);
    chk("slt_false", cdb_out, 32'd0);
    run_int(4'h9, 32'd5, 32'd6, 6'h05);
    chk("beq_ne", {cdb_valid, cdb_branch, cdb_branch_taken, cdb_tagout}, {3'b110, 6'h05});
    run_int(4'h9, 32'd6, 32'd6, 6'h06);
    chk("beq_eq", {cdb_out, cdb_branch, cdb_branch_taken}, {32'd0, 2'b11});
    run_int(4'h6, 32'h1, 32'hF, 6'h07);
    chk("nor", cdb_out, 32'hFFFF_FFF0);

    set_req(0, 0, 1, 0, 4'h0, 32'd6, 32'd3, 6'h0A);
    n0 = cyc;
    cycle();
    set_req(0, 0, 1, 0, 4'h0, 32'd9, 32'd2, 6'h0B);
    #1 chk("div_busy_block", issue_div, 0);
    repeat (3) cycle();
    idle();
    while (cyc < n0 + 33) cycle();
    chk("div_result", {cdb_valid, cdb_out, cdb_tagout, issue_div_done}, {1'b1, 32'd2, 6'h0A, 1'b1});
    cycle();
    chk("div_done_pulse", issue_div_done, 0);

    set_req(0, 1, 0, 0, 4'h0, 32'd3, 32'd4, 6'h11);
    n0 = cyc;
    cycle();
    idle();
    cycle();
    cycle();
    set_req(1, 0, 0, 0, 4'h0, 32'd1, 32'd2, 6'h12);
    #1 chk("int_slot_blocked", issue_int, 0);
    cycle();
    chk("int_after_mult", issue_int, 1);
    chk("mult_result", {cdb_valid, cdb_out, cdb_tagout}, {1'b1, 32'd12, 6'h11});
    cycle();
    idle();
    chk("int_after_mult_cdb", {cdb_valid, cdb_out, cdb_tagout}, {1'b1, 32'd3, 6'h12});

    set_req(1, 1, 0, 1, 4'h0, 32'd7, 32'd8, 6'h13);
    #1 chk("priority", {issue_div, issue_mult, issue_int, issue_ld_buf}, 4'b0100);
    cycle();
    idle();
    repeat (5) cycle();

    set_req(0, 0, 0, 1, 4'h0, 32'hDEAD_BEEF, 32'h0, 6'h14);
    cycle();
    idle();
    chk("ld_buf", {cdb_valid, cdb_out, cdb_tagout}, {1'b1, 32'hDEAD_BEEF, 6'h14});

    for (int i = 0; i < 1500; i++) begin
      ready_div    = ($urandom_range(0, 15) == 0);
      ready_mult   = ($urandom_range(0, 2) == 0);
      ready_int    = ($urandom_range(0, 1) == 0);
      ready_ld_buf = ($urandom_range(0, 2) == 0);
      opcode       = 4'($urandom_range(0, 15));
      rsdata       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
      rtdata       = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom();
      rdtag        = 6'($urandom_range(0, 63));
      cycle();
    end
    idle();
    repeat (40) cycle();

    set_req(0, 0, 1, 0, 4'h0, 32'd100, 32'd7, 6'h15);
    cycle();
    idle();
    repeat (10) cycle();
    hit_reset();
    repeat (40) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/issue_unit.md
Name: issue_unit

Overview:
- Issue stage of the out-of-order core, between the reservation-station ready queues and the common data bus (CDB).
- Each cycle it grants at most one requesting queue (int, mult, div, load buffer) and accepts that queue's operands on the shared operand bus.
- It executes the operation in an internal integer ALU, multiplier pipe or iterative divider.
- It schedules every result onto the single CDB without collision, using a slot-reservation register.

Parameters:
None. Data width is 32, tag width is 6; latencies are fixed as stated in Behaviour.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  4  int-ALU operation select, sampled on an issue_int grant
rsdata  input  32  operand A; load data when issue_ld_buf is granted
rtdata  input  32  operand B
rdtag  input  6  destination tag of the granted instruction
ready_int  input  1  int queue has a ready instruction
ready_mult  input  1  mult queue has a ready instruction
ready_div  input  1  div queue has a ready instruction
ready_ld_buf  input  1  load buffer has data ready for the CDB
issue_int  output  1  grant to int queue (combinational)
issue_mult  output  1  grant to mult queue
issue_div  output  1  grant to div queue
issue_ld_buf  output  1  grant to load buffer
issue_carryout  output  1  carry out of ADD/SUB, aligned with CDB
issue_overflow  output  1  signed overflow of ADD/SUB, aligned with CDB
issue_div_done  output  1  one-cycle pulse when the divider result is on the CDB
cdb_out  output  32  CDB result data
cdb_tagout  output  6  CDB result tag
cdb_valid  output  1  CDB carries a valid result
cdb_branch  output  1  CDB entry is a branch outcome
cdb_branch_taken  output  1  branch condition true

Behaviour:
- Reset (reset low, asynchronous):
  - Clears all pipelines, the divider, the reservation register and every CDB register.
  - All outputs read 0, including grants.
  - Reset mid-operation discards in-flight results; no late CDB write follows.
- Latency from a grant in cycle N to the CDB:
  - int: N+1
  - ld_buf: N+1
  - mult: N+4
  - div: N+33 (32 iterations plus output register)
- Reservation register: 33 bits. Bit k set means the CDB is taken k cycles ahead. It shifts every cycle and sets the latency bit of each grant.
- Grant rules:
  - A request is eligible only if its latency slot is free.
  - div is additionally eligible only when the divider is idle. The divider is busy from the grant until its result cycle, inclusive.
  - Priority among eligible requests: div > mult > int > ld_buf. Exactly one grant or none.
  - Operands and tag are captured at the clock edge that ends the grant cycle.
- Int ALU opcodes:
  - 0 ADD: signed; sets carry and overflow.
  - 1 ADDU: sets carry; overflow 0.
  - 2 SUB: rs-rt, signed; carry = no-borrow.
  - 3 SUBU.
  - 4 AND.
  - 5 OR.
  - 6 NOR.
  - 7 SLT: signed; result 1 or 0.
  - 8 SLTU.
  - 9 BEQ.
  - A BNE.
  - B-F: result 0, valid still asserted.
  - On overflow the result is still broadcast (no trap).
- Branches (9, A):
  - cdb_branch=1; cdb_branch_taken = (rs==rt) for BEQ, (rs!=rt) for BNE.
  - cdb_out=0.
  - cdb_valid=1 with the branch tag.
- Int flags: carry and overflow are 0 for non-add/sub ops and whenever the CDB carries a non-int result.
- Multiplier: 4-stage pipe, fully pipelined (one issue per cycle). Result = low 32 bits of rs*rt.
- Divider: unsigned restoring, one bit per cycle. Result = quotient; remainder is discarded. Divide by zero gives 0xFFFFFFFF.
- Load buffer: cdb_out = rsdata captured at grant; tag = rdtag.
- CDB outputs are registered. When no result is due, cdb_valid=0 and all CDB and flag outputs are 0.
- issue_div_done goes high only in the cycle the divider result drives the CDB.

Test Plan:
- After reset, ADD (opcode 0, rs=0xA, rt=0x5, tag 0x0E, ready_int=1) -> issue_int=1; next cycle cdb_valid=1, cdb_out=0xF, cdb_tagout=0x0E, carry=0, overflow=0.
- Divide rs=6, rt=3, tag 0x0A, ready_div=1 -> issue_div=1 for one cycle; a second ready_div while busy is not granted; 33 cycles later cdb_out=2, tag 0x0A, issue_div_done=1 for one cycle.
- ADD 0x7FFFFFFF+0x1 -> cdb_out=0x80000000, overflow=1, carry=0. ADD 0xFFFFFFFF+0xFFFFFFFF -> 0xFFFFFFFE, carry=1, overflow=0.
- SLT 5<6 -> cdb_out=1, and 6<5 -> 0. BEQ 5,6 -> branch=1, taken=0. BEQ 6,6 -> taken=1. NOR 0x1,0xF -> 0xFFFFFFF0.
- Mult 3*4 granted at N; ready_int at N+3 -> not granted (slot N+4 taken); granted at N+4. CDB shows 12 at N+4 and the int result at N+5.
- Simultaneous ready_mult, ready_int and ready_ld_buf -> only issue_mult. Assert reset during a divide -> no later CDB write, and all outputs are 0 immediately.
